// File: rtl/sym_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sym_pkg
//  Description : Shared definitions for the symbol tally game. Holds the
//                active-low 7-segment codes of the digits 0..9 (used both by
//                the symbol generator and the decoder), the digit value that
//                marks an undecodable code, and the tally FSM state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sym_pkg;

  // Active-low 7-segment codes, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] c_seg_0 = 8'hC0;
  localparam logic [7:0] c_seg_1 = 8'hF9;
  localparam logic [7:0] c_seg_2 = 8'hA4;
  localparam logic [7:0] c_seg_3 = 8'hB0;
  localparam logic [7:0] c_seg_4 = 8'h99;
  localparam logic [7:0] c_seg_5 = 8'h92;
  localparam logic [7:0] c_seg_6 = 8'h82;
  localparam logic [7:0] c_seg_7 = 8'hD8;
  localparam logic [7:0] c_seg_8 = 8'h80;
  localparam logic [7:0] c_seg_9 = 8'h90;

  // Digit reported for any code outside the table above
  localparam logic [3:0] c_digit_invalid = 4'hF;

  // Tally FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY       = 2'd1,
    WAIT_GUESS = 2'd2,
    RESULT     = 2'd3
  } state_t;

  // Generator-side helper: digit -> segment code. Digits above 9 map to an
  // all-off pattern, which the decoder treats as undecodable.
  function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    seg = 8'hFF;
    case (digit)
      4'd0:    seg = c_seg_0;
      4'd1:    seg = c_seg_1;
      4'd2:    seg = c_seg_2;
      4'd3:    seg = c_seg_3;
      4'd4:    seg = c_seg_4;
      4'd5:    seg = c_seg_5;
      4'd6:    seg = c_seg_6;
      4'd7:    seg = c_seg_7;
      4'd8:    seg = c_seg_8;
      4'd9:    seg = c_seg_9;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage : sym_pkg
`default_nettype wire

// File: rtl/seg_to_digit.sv
`default_nettype none
// ============================================================================
//  Module      : seg_to_digit
//  Description : Purely combinational decoder from an active-low 7-segment
//                code to its decimal digit. Codes not in the digit table
//                decode to 4'hF with o_valid low.
//  Ports       : i_code  [7:0] in  - 7-segment code (active low)
//                o_digit [3:0] out - decoded digit, 4'hF when undecodable
//                o_valid       out - 1 when i_code is one of the ten digits
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_to_digit
  import sym_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [3:0] o_digit,
  output logic       o_valid
);

  always_comb begin
    o_digit = c_digit_invalid;
    case (i_code)
      c_seg_0: o_digit = 4'd0;
      c_seg_1: o_digit = 4'd1;
      c_seg_2: o_digit = 4'd2;
      c_seg_3: o_digit = 4'd3;
      c_seg_4: o_digit = 4'd4;
      c_seg_5: o_digit = 4'd5;
      c_seg_6: o_digit = 4'd6;
      c_seg_7: o_digit = 4'd7;
      c_seg_8: o_digit = 4'd8;
      c_seg_9: o_digit = 4'd9;
      default: o_digit = c_digit_invalid;
    endcase
  end

  // No table entry decodes to 4'hF, so it doubles as the invalid marker.
  assign o_valid = (o_digit != c_digit_invalid);

endmodule : seg_to_digit
`default_nettype wire

// File: rtl/sym_tally.sv
`default_nettype none
// ============================================================================
//  Module      : sym_tally
//  Description : Counts symbols delivered during a game period, counts the
//                special (target) ones, tracks the last decoded digit and a
//                sticky bad-code flag, then compares the player's guess with
//                the special count.
//  Ports       : Clk100M            in  - clock, rising edge
//                Reset              in  - asynchronous active-high reset
//                genSym             in  - game period active
//                generated          in  - one-cycle symbol strobe
//                special            in  - qualifies generated as target symbol
//                generatedSym [7:0] in  - active-low 7-segment code
//                guess [CNT_W-1:0]  in  - claimed special count
//                submit             in  - one-cycle guess commit strobe
//                symCount     [CNT_W-1:0] out - symbols this game (saturating)
//                specialCount [CNT_W-1:0] out - specials this game (saturating)
//                lastDigit    [3:0]       out - last decoded digit, 4'hF if bad
//                badSym             out - sticky undecodable-code flag
//                done               out - result valid
//                correct            out - guess matched, valid with done
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_tally
  import sym_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clk100M,
  input  logic             Reset,
  input  logic             genSym,
  input  logic             generated,
  input  logic             special,
  input  logic [7:0]       generatedSym,
  input  logic [CNT_W-1:0] guess,
  input  logic             submit,
  output logic [CNT_W-1:0] symCount,
  output logic [CNT_W-1:0] specialCount,
  output logic [3:0]       lastDigit,
  output logic             badSym,
  output logic             done,
  output logic             correct
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           r_state,      w_state_nxt;
  logic [CNT_W-1:0] r_sym_cnt,    w_sym_cnt_nxt;
  logic [CNT_W-1:0] r_spc_cnt,    w_spc_cnt_nxt;
  logic [3:0]       r_last_digit, w_last_digit_nxt;
  logic             r_bad_sym,    w_bad_sym_nxt;
  logic             r_done,       w_done_nxt;
  logic             r_correct,    w_correct_nxt;

  logic [3:0]       w_dec_digit;
  logic             w_dec_valid;
  logic             w_start;

  // Decode feeds the lastDigit register directly: strobe -> output in 1 cycle.
  seg_to_digit u_seg_to_digit (
    .i_code  (generatedSym),
    .o_digit (w_dec_digit),
    .o_valid (w_dec_valid)
  );

  // A new game may start from any non-PLAY state and overrides submit.
  assign w_start = genSym && (r_state != PLAY);

  always_comb begin
    w_state_nxt      = r_state;
    w_sym_cnt_nxt    = r_sym_cnt;
    w_spc_cnt_nxt    = r_spc_cnt;
    w_last_digit_nxt = r_last_digit;
    w_bad_sym_nxt    = r_bad_sym;
    w_done_nxt       = r_done;
    w_correct_nxt    = r_correct;

    if (w_start) begin
      w_state_nxt      = PLAY;
      w_sym_cnt_nxt    = '0;
      w_spc_cnt_nxt    = '0;
      w_last_digit_nxt = c_digit_invalid;
      w_bad_sym_nxt    = 1'b0;
      w_done_nxt       = 1'b0;
      w_correct_nxt    = 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          // Strobes are still counted on the edge where genSym falls.
          if (generated) begin
            if (r_sym_cnt != c_cnt_max) begin
              w_sym_cnt_nxt = r_sym_cnt + c_cnt_one;
            end
            if (special && (r_spc_cnt != c_cnt_max)) begin
              w_spc_cnt_nxt = r_spc_cnt + c_cnt_one;
            end
            w_last_digit_nxt = w_dec_digit;
            if (!w_dec_valid) begin
              w_bad_sym_nxt = 1'b1;
            end
          end
          if (!genSym) begin
            w_state_nxt = WAIT_GUESS;
          end
        end
        WAIT_GUESS: begin
          if (submit) begin
            w_state_nxt   = RESULT;
            w_done_nxt    = 1'b1;
            w_correct_nxt = (guess == r_spc_cnt);
          end
        end
        IDLE, RESULT: begin
          // Hold everything; strobes and submits are ignored here.
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_sym_cnt    <= '0;
      r_spc_cnt    <= '0;
      r_last_digit <= c_digit_invalid;
      r_bad_sym    <= 1'b0;
      r_done       <= 1'b0;
      r_correct    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sym_cnt    <= w_sym_cnt_nxt;
      r_spc_cnt    <= w_spc_cnt_nxt;
      r_last_digit <= w_last_digit_nxt;
      r_bad_sym    <= w_bad_sym_nxt;
      r_done       <= w_done_nxt;
      r_correct    <= w_correct_nxt;
    end
  end

  assign symCount     = r_sym_cnt;
  assign specialCount = r_spc_cnt;
  assign lastDigit    = r_last_digit;
  assign badSym       = r_bad_sym;
  assign done         = r_done;
  assign correct      = r_correct;

endmodule : sym_tally
`default_nettype wire

// File: tb/tb_sym_tally.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sym_tally
//  Description : Self-checking bench for sym_tally. Each scenario task drives
//                one cycle at a time, pushes the expected output record to a
//                scoreboard queue, then pops and compares once the edge has
//                produced the DUT output.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sym_tally;
  import sym_pkg::*;

  typedef struct packed {
    logic [7:0] sym;
    logic [7:0] spc;
    logic [3:0] dig;
    logic       bad;
    logic       dn;
    logic       cor;
  } res_t;

  logic       Clk100M;
  logic       Reset;
  logic       genSym;
  logic       generated;
  logic       special;
  logic [7:0] generatedSym;
  logic [7:0] guess;
  logic       submit;
  logic [7:0] symCount;
  logic [7:0] specialCount;
  logic [3:0] lastDigit;
  logic       badSym;
  logic       done;
  logic       correct;

  res_t  obs;
  res_t  sb_q[$];
  string nm_q[$];
  int    tests_run;
  int    tests_failed;

  sym_tally #(.CNT_W(8)) dut (
    .Clk100M      (Clk100M),
    .Reset        (Reset),
    .genSym       (genSym),
    .generated    (generated),
    .special      (special),
    .generatedSym (generatedSym),
    .guess        (guess),
    .submit       (submit),
    .symCount     (symCount),
    .specialCount (specialCount),
    .lastDigit    (lastDigit),
    .badSym       (badSym),
    .done         (done),
    .correct      (correct)
  );

  assign obs = {symCount, specialCount, lastDigit, badSym, done, correct};

  initial begin
    Clk100M = 1'b0;
    forever #5 Clk100M = ~Clk100M;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(input int s, input int p, input logic [3:0] d,
                              input logic b, input logic dn, input logic c);
    res_t r;
    r = {s[7:0], p[7:0], d, b, dn, c};
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic tick(input logic gs, input logic gen, input logic sp,
                      input logic [7:0] code, input logic sub, input logic [7:0] g);
    genSym       = gs;
    generated    = gen;
    special      = sp;
    generatedSym = code;
    submit       = sub;
    guess        = g;
    @(posedge Clk100M);
    #1;
    generated = 1'b0;
    special   = 1'b0;
    submit    = 1'b0;
  endtask

  task automatic test_reset();
    res_t  e;
    string n;
    Reset = 1'b1;
    repeat (2) @(posedge Clk100M);
    #1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
      nm_q.push_back($sformatf("reset_step%0d", i));
      case (i)
        0: ;                                                  // still in reset
        1: begin Reset = 1'b0; tick(1'b0, 1'b1, 1'b1, c_seg_3, 1'b0, 8'd0); end
        default: tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0);  // submit in IDLE
      endcase
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL %s: got sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b expected sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b",
                 n, obs.sym, obs.spc, obs.dig, obs.bad, obs.dn, obs.cor,
                 e.sym, e.spc, e.dig, e.bad, e.dn, e.cor);
      end
    end
  endtask

  // Full game: digits 0..4, special on the 2nd and 4th strobe, then a guess.
  task automatic test_game(input logic [7:0] g, input logic exp_cor);
    res_t  e;
    string n;
    int    spc_exp;
    spc_exp = 0;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin
          sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
          nm_q.push_back($sformatf("game%0d_start", g));
          tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        end
        1, 2, 3, 4, 5: begin
          if (i == 2 || i == 4) spc_exp++;
          sb_q.push_back(mk(i, spc_exp, 4'(i - 1), 1'b0, 1'b0, 1'b0));
          nm_q.push_back($sformatf("game%0d_strobe%0d", g, i));
          tick(1'b1, 1'b1, (i == 2 || i == 4), digit_to_seg(4'(i - 1)), 1'b0, 8'd0);
        end
        6: begin
          sb_q.push_back(mk(5, 2, 4'd4, 1'b0, 1'b0, 1'b0));
          nm_q.push_back($sformatf("game%0d_wait", g));
          tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
        end
        7: begin
          sb_q.push_back(mk(5, 2, 4'd4, 1'b0, 1'b1, exp_cor));
          nm_q.push_back($sformatf("game%0d_submit", g));
          tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, g);
        end
        8: begin
          sb_q.push_back(mk(5, 2, 4'd4, 1'b0, 1'b1, exp_cor));
          nm_q.push_back($sformatf("game%0d_resubmit_ignored", g));
          tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, (g == 8'd2) ? 8'd3 : 8'd2);
        end
        default: begin
          sb_q.push_back(mk(5, 2, 4'd4, 1'b0, 1'b1, exp_cor));
          nm_q.push_back($sformatf("game%0d_result_strobe_ignored", g));
          tick(1'b0, 1'b1, 1'b1, c_seg_9, 1'b0, 8'd0);
        end
      endcase
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL %s: got sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b expected sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b",
                 n, obs.sym, obs.spc, obs.dig, obs.bad, obs.dn, obs.cor,
                 e.sym, e.spc, e.dig, e.bad, e.dn, e.cor);
      end
    end
  endtask

  // Undecodable code mid-game, sticky flag, then genSym beating submit.
  task automatic test_badsym();
    res_t  e;
    string n;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
                 tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0); end
        1: begin sb_q.push_back(mk(1, 0, 4'd0, 1'b0, 1'b0, 1'b0));
                 tick(1'b1, 1'b1, 1'b0, c_seg_0, 1'b0, 8'd0); end
        2: begin sb_q.push_back(mk(2, 1, 4'hF, 1'b1, 1'b0, 1'b0));
                 tick(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'd0); end
        3: begin sb_q.push_back(mk(3, 1, 4'd1, 1'b1, 1'b0, 1'b0));
                 tick(1'b1, 1'b1, 1'b0, c_seg_1, 1'b0, 8'd0); end
        4: begin sb_q.push_back(mk(3, 1, 4'd1, 1'b1, 1'b0, 1'b0));
                 tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0); end
        default: begin sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
                 tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'd1); end
      endcase
      nm_q.push_back($sformatf("badsym_step%0d", i));
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL %s: got sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b expected sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b",
                 n, obs.sym, obs.spc, obs.dig, obs.bad, obs.dn, obs.cor,
                 e.sym, e.spc, e.dig, e.bad, e.dn, e.cor);
      end
    end
  endtask

  // Entered in PLAY with cleared state: strobe on genSym fall counts, next one not.
  task automatic test_late_strobe();
    res_t  e;
    string n;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sb_q.push_back(mk(1, 0, 4'd5, 1'b0, 1'b0, 1'b0));
                 tick(1'b0, 1'b1, 1'b0, c_seg_5, 1'b0, 8'd0); end
        1: begin sb_q.push_back(mk(1, 0, 4'd5, 1'b0, 1'b0, 1'b0));
                 tick(1'b0, 1'b1, 1'b1, c_seg_6, 1'b0, 8'd0); end
        default: begin sb_q.push_back(mk(1, 0, 4'd5, 1'b0, 1'b1, 1'b0));
                 tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd1); end
      endcase
      nm_q.push_back($sformatf("late_strobe_step%0d", i));
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL %s: got sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b expected sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b",
                 n, obs.sym, obs.spc, obs.dig, obs.bad, obs.dn, obs.cor,
                 e.sym, e.spc, e.dig, e.bad, e.dn, e.cor);
      end
    end
  endtask

  // 300 special strobes: both counters must stop at 255.
  task automatic test_saturate();
    res_t  e;
    string n;
    int    c;
    for (int i = 0; i < 303; i++) begin
      if (i == 0) begin
        sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
      end else if (i <= 300) begin
        c = (i > 255) ? 255 : i;
        sb_q.push_back(mk(c, c, 4'd8, 1'b0, 1'b0, 1'b0));
        tick(1'b1, 1'b1, 1'b1, c_seg_8, 1'b0, 8'd0);
      end else if (i == 301) begin
        sb_q.push_back(mk(255, 255, 4'd8, 1'b0, 1'b0, 1'b0));
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
      end else begin
        sb_q.push_back(mk(255, 255, 4'd8, 1'b0, 1'b1, 1'b1));
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd255);
      end
      nm_q.push_back($sformatf("saturate_step%0d", i));
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL %s: got sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b expected sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b",
                 n, obs.sym, obs.spc, obs.dig, obs.bad, obs.dn, obs.cor,
                 e.sym, e.spc, e.dig, e.bad, e.dn, e.cor);
      end
    end
  endtask

  // Reset pulse between clock edges while in PLAY with symCount=3.
  task automatic test_mid_reset();
    res_t  e;
    string n;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
                 tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0); end
        1, 2, 3: begin sb_q.push_back(mk(i, 1, 4'd7, 1'b0, 1'b0, 1'b0));
                 tick(1'b1, 1'b1, (i == 1), c_seg_7, 1'b0, 8'd0); end
        4: begin
          sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
          #2 Reset = 1'b1;
          #1;                              // no clock edge in between
        end
        5: begin
          #1 Reset = 1'b0;
          sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
          tick(1'b0, 1'b1, 1'b0, c_seg_2, 1'b0, 8'd0);
        end
        6: begin sb_q.push_back(mk(0, 0, 4'hF, 1'b0, 1'b0, 1'b0));
                 tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0); end
        default: begin sb_q.push_back(mk(1, 0, 4'd3, 1'b0, 1'b0, 1'b0));
                 tick(1'b1, 1'b1, 1'b0, c_seg_3, 1'b0, 8'd0); end
      endcase
      nm_q.push_back($sformatf("mid_reset_step%0d", i));
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL %s: got sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b expected sym=%0d spc=%0d dig=%h bad=%b done=%b cor=%b",
                 n, obs.sym, obs.spc, obs.dig, obs.bad, obs.dn, obs.cor,
                 e.sym, e.spc, e.dig, e.bad, e.dn, e.cor);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b1;
    genSym       = 1'b0;
    generated    = 1'b0;
    special      = 1'b0;
    generatedSym = 8'h00;
    guess        = 8'd0;
    submit       = 1'b0;

    test_reset();
    test_game(8'd2, 1'b1);
    test_game(8'd3, 1'b0);
    test_badsym();
    test_late_strobe();
    test_saturate();
    test_mid_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sym_tally
`default_nettype wire

// File: doc/sym_tally.md
SYM_TALLY -- requirements
Module: sym_tally

Interface
REQ-001 Parameter CNT_W, default 8, width of the symbol and special counters and of guess.
REQ-002 Clk100M  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 genSym  in  1  game period active.
REQ-005 generated  in  1  single-cycle strobe, one symbol delivered.
REQ-006 special  in  1  qualifies generated; the delivered symbol is the target symbol.
REQ-007 generatedSym  in  8  active-low 7-segment code of the delivered symbol, valid when generated=1.
REQ-008 guess  in  CNT_W  player's claimed special count, sampled on submit.
REQ-009 submit  in  1  single-cycle strobe, player commits guess.
REQ-010 symCount  out  CNT_W  symbols received this game.
REQ-011 specialCount  out  CNT_W  special symbols received this game.
REQ-012 lastDigit  out  4  decoded digit of the most recent symbol; 4'hF if undecodable.
REQ-013 badSym  out  1  sticky flag: an undecodable code was received this game.
REQ-014 done  out  1  result valid.
REQ-015 correct  out  1  guess equalled specialCount; meaningful only when done=1.

Function
REQ-016 The FSM SHALL have states IDLE, PLAY, WAIT_GUESS and RESULT.
REQ-017 IDLE/RESULT/WAIT_GUESS with genSym=1 -> PLAY; in that same edge symCount, specialCount, badSym, done and correct clear to 0 and lastDigit to 4'hF.
REQ-018 PLAY with genSym=0 -> WAIT_GUESS.
REQ-019 In PLAY, each cycle with generated=1 SHALL increment symCount by 1, registered, visible the following cycle.
REQ-020 In PLAY, generated=1 with special=1 SHALL also increment specialCount in the same edge; special with generated=0 is ignored.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 A strobe arriving on the cycle genSym deasserts, while still in PLAY, SHALL be counted.
REQ-023 Strobes in IDLE, WAIT_GUESS and RESULT SHALL be ignored.
REQ-024 Decode table, code->digit: C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, D8->7, 80->8, 90->9; any other code -> 4'hF.
REQ-025 An undecodable symbol SHALL set badSym and lastDigit=4'hF.
REQ-026 An undecodable symbol SHALL still be counted in symCount, and in specialCount if special=1.
REQ-027 WAIT_GUESS with submit=1 and genSym=0 -> RESULT; correct <= (guess == specialCount) using the pre-edge count; done <= 1.
REQ-028 genSym=1 takes priority over a simultaneous submit.
REQ-029 In RESULT, done, correct and all counters SHALL hold; further submits SHALL be ignored.
REQ-030 The decode path SHALL be combinational into the lastDigit register, with no extra pipeline stage (1-cycle latency strobe->outputs).

Reset
REQ-031 Reset=1 SHALL asynchronously force state IDLE, symCount=0, specialCount=0, lastDigit=4'hF, badSym=0, done=0 and correct=0.
REQ-032 Reset asserted mid-game SHALL discard all progress.
REQ-033 After Reset deasserts, the first rising edge with genSym=1 SHALL enter PLAY.

Structure
REQ-034 Shared package sym_pkg SHALL hold the ten segment-code constants, the 4'hF invalid-digit constant and the FSM state enum.
REQ-035 The segment-code constants in sym_pkg SHALL also be used by the symbol generator.
REQ-036 One combinational sub-module seg_to_digit SHALL hold the decode (8-bit code in, 4-bit digit plus valid out).

Verification
REQ-037 Reset, genSym=1, then 5 strobes with codes C0,F9,A4,B0,99 (special on the 2nd and 4th) -> symCount=5, specialCount=2, lastDigit=4; genSym=0, guess=2, submit -> done=1, correct=1.
REQ-038 Same game with guess=3 -> done=1, correct=0.
REQ-039 Strobe with code 0xFF mid-game -> lastDigit=F, badSym=1, symCount incremented.
REQ-040 CNT_W=8, 300 special strobes -> symCount=specialCount=255.
REQ-041 Strobe on the cycle genSym falls is counted; strobe one cycle later is not counted.
REQ-042 Reset pulse in PLAY with symCount=3 -> all outputs at reset values asynchronously.
REQ-043 genSym reasserted in RESULT -> counters clear, done=0, state PLAY.
